shift_case_decoder: RTL and testbench

- Inverse end of the case-selected left-shift encoder, which produces y = x << sel with sel in 0..3.
- Accepts an encoded word y and recovers sel as the trailing-zero count of y, capped at 3. Recovers x as y >> sel.
- Iterative: one right-shift per cycle, valid/ready handshake on both sides.
- Sits on the receive side of the shift-encoded datapath.

---
 rtl/shift_case_pkg.sv | 6 +
 rtl/shift_case_decoder.sv | 72 +++++++
 tb/tb_shift_case_decoder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/shift_case_pkg.sv
// shift_case_pkg: constants and decoder state type shared by the shift encoder and decoder
package shift_case_pkg;
    localparam int SEL_W = 2;
    localparam int MAX_SHIFT = 3;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_dec_state_t;
endpackage

// File: rtl/shift_case_decoder.sv
// shift_case_decoder: iterative trailing-zero decoder of y = x << sel; SHIFT_CASE_DECODER_STATS_EN adds stat_count
module shift_case_decoder
    import shift_case_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_sel,
    input  logic             out_ready
`ifdef SHIFT_CASE_DECODER_STATS_EN
    ,
    output logic [15:0]      stat_count
`endif
);
    shift_dec_state_t state;
    logic [WIDTH-1:0] sreg;
    logic [SEL_W-1:0] cnt;
    logic stop;
    // a zero word or a set LSB ends the shift; so does reaching the maximum shift amount
    always_comb stop = (sreg == '0) || sreg[0] || (cnt == SEL_W'(MAX_SHIFT));
    // FSM with datapath and registered handshake/result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sreg     <= in_data;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    state    <= SHIFT;
                end
                SHIFT: if (stop) begin
                    out_valid <= 1'b1;
                    out_data  <= sreg;
                    out_sel   <= cnt;
                    state     <= DONE;
                end else begin
                    sreg <= sreg >> 1;
                    cnt  <= cnt + SEL_W'(1);
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_sel   <= '0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef SHIFT_CASE_DECODER_STATS_EN
    // saturating count of completed output transfers
    always_ff @(posedge clk) begin
        if (!rst_n) stat_count <= '0;
        else if (out_valid && out_ready && stat_count != 16'hFFFF) stat_count <= stat_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_shift_case_decoder.sv
// tb_shift_case_decoder: directed and random decode checks against a trailing-zero reference model
module tb_shift_case_decoder;
    localparam int W = 8;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [1:0] out_sel;
    int checks = 0, errors = 0, xfers = 0;
`ifdef SHIFT_CASE_DECODER_STATS_EN
    logic [15:0] stat_count;
`endif

    always #5 clk = ~clk;

    shift_case_decoder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
`ifdef SHIFT_CASE_DECODER_STATS_EN
        , .stat_count(stat_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sel", out_sel, 0);
`ifdef SHIFT_CASE_DECODER_STATS_EN
        chk("rst_stat_count", stat_count, 0);
`endif
    endtask

    // send one word, hold off the consumer for `stall` cycles, then complete the transfer
    task automatic decode(input logic [W-1:0] y, input int stall, input logic pulse);
        int tz, esel, n;
        logic [W-1:0] ex;
        tz = 0;
        while (tz < W && y[tz] == 1'b0) tz++;
        esel = (y == '0) ? 0 : (tz > 3 ? 3 : tz);
        ex = y >> esel;
        n = 0;
        while (!in_ready && n < 20) begin
            tick;
            n++;
        end
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_data = y;
        out_ready = (stall == 0);
        tick;
        in_valid = 1'b0;
        in_data = W'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            chk("in_ready_busy", in_ready, 0);
            tick;
            n++;
        end
        chk("latency", n, esel + 1);
        chk("out_data", out_data, ex);
        chk("out_sel", out_sel, esel);
        chk("in_ready_done", in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            if (pulse && i == 1) in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, ex);
            chk("stall_sel", out_sel, esel);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick;
        xfers++;
        out_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
`ifdef SHIFT_CASE_DECODER_STATS_EN
        chk("stat_count", stat_count, xfers);
`endif
    endtask

    initial begin
        tick;
        tick;
        chk_reset_values;
        rst_n = 1'b1;
        tick;
        decode(8'h28, 0, 1'b0);
        decode(8'h50, 0, 1'b0);
        decode(8'h07, 0, 1'b0);
        decode(8'h00, 0, 1'b0);
        decode(8'h0C, 5, 1'b1);
        decode(8'h80, 2, 1'b0);
        decode(8'hFF, 1, 1'b0);
        in_valid = 1'b1;
        in_data = 8'h80;
        tick;
        in_valid = 1'b0;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        xfers = 0;
        chk_reset_values;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("abort_no_valid", out_valid, 0);
        end
        decode(8'h02, 0, 1'b0);
        for (int k = 0; k < 40; k++)
            decode(W'($urandom) << $urandom_range(0, 5), $urandom_range(0, 2), 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
